// File: rtl/conv1d_pkg.sv
// Shared types and helpers for the conv1d tap sequencer: data widths,
// FSM state encodings and the 16-bit saturation function.
package conv1d_pkg;

    localparam int DATA_W  = 16;
    localparam int PROD_W  = 32;
    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_ISSUE = 3'd1;
    localparam logic [STATE_W-1:0] S_DRAIN = 3'd2;
    localparam logic [STATE_W-1:0] S_OUT   = 3'd3;
    localparam logic [STATE_W-1:0] S_DONE  = 3'd4;

    // Clamp a signed value (sign-extended to 64 bits by the caller) to [-32768, 32767].
    function automatic logic [DATA_W-1:0] sat16(input logic signed [63:0] v);
        if (v > 64'sd32767) begin
            return 16'h7fff;
        end else if (v < -64'sd32768) begin
            return 16'h8000;
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/conv1d_round_sat.sv
// Combinational output stage: round-half-up, arithmetic shift by SHIFT,
// then saturate to a signed 16-bit sample. ACC_W+1 must not exceed 64.
module conv1d_round_sat
    import conv1d_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int SHIFT = 8
)(
    input  logic [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0] y
);

    localparam int SH1 = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] BIAS = (SHIFT > 0) ? ((ACC_W + 1)'(1) << SH1) : '0;

    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] shifted;

    // One guard bit keeps the rounding bias from wrapping near full scale.
    always_comb begin
        biased  = $signed({acc[ACC_W-1], acc}) + BIAS;
        shifted = biased >>> SHIFT;
        y       = sat16(64'(shifted));
    end

endmodule

// File: rtl/conv1d_tap_sequencer.sv
// Drives one shared external 16x16 multiplier through a K-tap 1-D convolution,
// one output at a time, behind an ap_start/ap_done control handshake.
module conv1d_tap_sequencer
    import conv1d_pkg::*;
#(
    parameter int K     = 5,
    parameter int N_OUT = 256,
    parameter int ACC_W = 40,
    parameter int SHIFT = 8,
    localparam int XA_W = ($clog2(N_OUT + K - 1) < 1) ? 1 : $clog2(N_OUT + K - 1),
    localparam int WA_W = ($clog2(K) < 1) ? 1 : $clog2(K)
)(
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [XA_W-1:0]   x_addr,
    output logic              x_ce,
    input  logic [DATA_W-1:0] x_q,
    output logic [WA_W-1:0]   w_addr,
    output logic              w_ce,
    input  logic [DATA_W-1:0] w_q,
    output logic [DATA_W-1:0] mul_din0,
    output logic [DATA_W-1:0] mul_din1,
    input  logic [PROD_W-1:0] mul_dout,
    output logic [DATA_W-1:0] y_data,
    output logic              y_valid,
    input  logic              y_ready
);

    localparam logic [WA_W-1:0] K_LAST = WA_W'(K - 1);
    localparam logic [XA_W-1:0] N_LAST = XA_W'(N_OUT - 1);

    logic [STATE_W-1:0]       state;
    logic [XA_W-1:0]          n;
    logic [WA_W-1:0]          k;
    logic                     drain_cnt;
    logic                     s1_valid;
    logic                     s2_valid;
    logic signed [PROD_W-1:0] p_reg;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic [DATA_W-1:0]        y_reg;
    logic [DATA_W-1:0]        rs_y;
    logic                     handshake;

    // Control FSM: walks taps in ISSUE, waits out the 2-stage pipe, then offers y.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state     <= S_IDLE;
            n         <= '0;
            k         <= '0;
            drain_cnt <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        n     <= '0;
                        k     <= '0;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (k == K_LAST) begin
                        k         <= '0;
                        drain_cnt <= 1'b0;
                        state     <= S_DRAIN;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt) begin
                        state <= S_OUT;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (handshake) begin
                        if (n == N_LAST) begin
                            state <= S_DONE;
                        end else begin
                            n     <= n + 1'b1;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Multiply pipeline valid bits; reset discards any product still in flight.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            p_reg    <= '0;
        end else begin
            s1_valid <= (state == S_ISSUE);
            s2_valid <= s1_valid;
            if (s1_valid) begin
                p_reg <= $signed(mul_dout);
            end
        end
    end

    // Next accumulator value, also fed to the output stage so the last product is included.
    always_comb begin
        acc_next = acc;
        if (s2_valid) begin
            acc_next = acc + ACC_W'(p_reg);
        end
    end

    // Accumulator is cleared at frame start and after each accepted output.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc <= '0;
        end else if ((state == S_IDLE && ap_start) || handshake) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

    // Output sample is captured on the way into OUT and held during backpressure.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            y_reg <= '0;
        end else if (state == S_DRAIN && drain_cnt) begin
            y_reg <= rs_y;
        end
    end

    conv1d_round_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .acc (acc_next),
        .y   (rs_y)
    );

    // Port decode: memory reads only in ISSUE, multiplier operands zero when S1 idle.
    always_comb begin
        ap_idle   = (state == S_IDLE);
        ap_done   = (state == S_DONE);
        ap_ready  = (state == S_DONE);
        x_ce      = (state == S_ISSUE);
        w_ce      = (state == S_ISSUE);
        x_addr    = '0;
        w_addr    = '0;
        if (state == S_ISSUE) begin
            x_addr = n + XA_W'(k);
            w_addr = k;
        end
        mul_din0  = s1_valid ? x_q : '0;
        mul_din1  = s1_valid ? w_q : '0;
        y_valid   = (state == S_OUT);
        y_data    = y_reg;
        handshake = (state == S_OUT) && y_ready;
    end

endmodule

// File: tb/tb_conv1d_tap_sequencer.sv
// Directed bench for conv1d_tap_sequencer: three instances cover the basic
// K=3 case (plus backpressure, reset and back-to-back), K=5 saturation and
// K=1 rounding. Only one instance is exercised at a time via sel.
module tb_conv1d_tap_sequencer;

    logic ap_clk;
    logic rst;
    logic start;
    logic ready;
    int   sel;

    int checks;
    int passes;
    int done_cnt;
    int got_cnt;
    int first_ce;
    int stall_bad;
    int got_y[0:7];
    int valid_at[0:7];

    // Instance A: K=3, N_OUT=4, SHIFT=0
    logic        a_done, a_idle, a_rdy, a_x_ce, a_w_ce, a_yv;
    logic [2:0]  a_x_addr;
    logic [1:0]  a_w_addr;
    logic [15:0] a_x_q, a_w_q, a_din0, a_din1, a_y;
    logic [31:0] a_dout;
    logic [15:0] ax[0:7];
    logic [15:0] aw[0:3];

    // Instance B: K=5, N_OUT=2, SHIFT=0
    logic        b_done, b_idle, b_rdy, b_x_ce, b_w_ce, b_yv;
    logic [2:0]  b_x_addr;
    logic [2:0]  b_w_addr;
    logic [15:0] b_x_q, b_w_q, b_din0, b_din1, b_y;
    logic [31:0] b_dout;
    logic [15:0] bx[0:7];
    logic [15:0] bw[0:7];

    // Instance C: K=1, N_OUT=2, SHIFT=8
    logic        c_done, c_idle, c_rdy, c_x_ce, c_w_ce, c_yv;
    logic [0:0]  c_x_addr;
    logic [0:0]  c_w_addr;
    logic [15:0] c_x_q, c_w_q, c_din0, c_din1, c_y;
    logic [31:0] c_dout;
    logic [15:0] cx[0:1];
    logic [15:0] cw[0:1];

    logic        m_valid, m_done, m_idle, m_ce;
    logic [15:0] m_data;

    conv1d_tap_sequencer #(.K(3), .N_OUT(4), .ACC_W(40), .SHIFT(0)) dut_a (
        .ap_clk(ap_clk), .ap_rst(rst), .ap_start(start && sel == 0),
        .ap_done(a_done), .ap_idle(a_idle), .ap_ready(a_rdy),
        .x_addr(a_x_addr), .x_ce(a_x_ce), .x_q(a_x_q),
        .w_addr(a_w_addr), .w_ce(a_w_ce), .w_q(a_w_q),
        .mul_din0(a_din0), .mul_din1(a_din1), .mul_dout(a_dout),
        .y_data(a_y), .y_valid(a_yv), .y_ready(ready && sel == 0)
    );

    conv1d_tap_sequencer #(.K(5), .N_OUT(2), .ACC_W(40), .SHIFT(0)) dut_b (
        .ap_clk(ap_clk), .ap_rst(rst), .ap_start(start && sel == 1),
        .ap_done(b_done), .ap_idle(b_idle), .ap_ready(b_rdy),
        .x_addr(b_x_addr), .x_ce(b_x_ce), .x_q(b_x_q),
        .w_addr(b_w_addr), .w_ce(b_w_ce), .w_q(b_w_q),
        .mul_din0(b_din0), .mul_din1(b_din1), .mul_dout(b_dout),
        .y_data(b_y), .y_valid(b_yv), .y_ready(ready && sel == 1)
    );

    conv1d_tap_sequencer #(.K(1), .N_OUT(2), .ACC_W(40), .SHIFT(8)) dut_c (
        .ap_clk(ap_clk), .ap_rst(rst), .ap_start(start && sel == 2),
        .ap_done(c_done), .ap_idle(c_idle), .ap_ready(c_rdy),
        .x_addr(c_x_addr), .x_ce(c_x_ce), .x_q(c_x_q),
        .w_addr(c_w_addr), .w_ce(c_w_ce), .w_q(c_w_q),
        .mul_din0(c_din0), .mul_din1(c_din1), .mul_dout(c_dout),
        .y_data(c_y), .y_valid(c_yv), .y_ready(ready && sel == 2)
    );

    // Combinational multipliers standing in for the external shared unit.
    assign a_dout = 32'($signed(a_din0)) * 32'($signed(a_din1));
    assign b_dout = 32'($signed(b_din0)) * 32'($signed(b_din1));
    assign c_dout = 32'($signed(c_din0)) * 32'($signed(c_din1));

    // Synchronous-read sample buffers and weight ROMs.
    always @(posedge ap_clk) begin
        if (a_x_ce) a_x_q <= ax[a_x_addr];
        if (a_w_ce) a_w_q <= aw[a_w_addr];
        if (b_x_ce) b_x_q <= bx[b_x_addr];
        if (b_w_ce) b_w_q <= bw[b_w_addr];
        if (c_x_ce) c_x_q <= cx[c_x_addr];
        if (c_w_ce) c_w_q <= cw[c_w_addr];
    end

    // Route the selected instance's outputs to the shared observation signals.
    always_comb begin
        case (sel)
            0:       begin m_valid = a_yv; m_data = a_y; m_done = a_done; m_idle = a_idle; m_ce = a_x_ce | a_w_ce; end
            1:       begin m_valid = b_yv; m_data = b_y; m_done = b_done; m_idle = b_idle; m_ce = b_x_ce | b_w_ce; end
            default: begin m_valid = c_yv; m_data = c_y; m_done = c_done; m_idle = c_idle; m_ce = c_x_ce | c_w_ce; end
        endcase
    end

    // Count ap_done cycles of the selected instance.
    always @(posedge ap_clk) begin
        if (m_done) done_cnt <= done_cnt + 1;
    end

    // Free-running clock.
    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    // Hard stop in case something wedges outside the bounded loops.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got %0d expected %0d checks", checks, 0);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic applyStimulus(input int which);
        sel   = which;
        start = 1'b1;
    endtask

    task automatic collectFrame(input int nOut, input int stallIdx, input int stallLen,
                                input int busyAt, input bit holdStart);
        int          cyc;
        logic [15:0] held;
        cyc       = 0;
        got_cnt   = 0;
        first_ce  = -1;
        stall_bad = 0;
        ready     = 1'b1;
        while (got_cnt < nOut && cyc < 400) begin
            @(negedge ap_clk);
            cyc++;
            if (!holdStart) start = (cyc == busyAt);
            if (m_ce && first_ce < 0) first_ce = cyc;
            if (m_valid) begin
                if (got_cnt == stallIdx && stallLen > 0) begin
                    ready = 1'b0;
                    held  = m_data;
                    for (int i = 0; i < stallLen; i++) begin
                        @(negedge ap_clk);
                        cyc++;
                        if (!m_valid || m_data != held || m_ce) stall_bad++;
                    end
                    ready = 1'b1;
                end
                valid_at[got_cnt] = cyc;
                got_y[got_cnt]    = int'($signed(m_data));
                got_cnt++;
            end
        end
        checkOutput("frame_len", got_cnt, nOut);
        @(negedge ap_clk);
        checkOutput("done_pulse", int'(m_done), 1);
        @(negedge ap_clk);
        checkOutput("done_cleared", int'(m_done), 0);
        checkOutput("idle_after_done", int'(m_idle), 1);
    endtask

    task automatic checkBasicFrame(input string tag);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s_y%0d", tag, i), got_y[i], 8 + 6 * i);
        end
    endtask

    initial begin
        int d0;
        int ce_seen;
        checks   = 0;
        passes   = 0;
        done_cnt = 0;
        sel      = 0;
        start    = 1'b0;
        ready    = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < 8; i++) ax[i] = 16'(i);
        aw[0] = 16'd1; aw[1] = 16'd2; aw[2] = 16'd3; aw[3] = 16'd0;
        for (int i = 0; i < 8; i++) begin bx[i] = 16'h7fff; bw[i] = 16'h7fff; end
        cx[0] = 16'd384; cx[1] = 16'hfe80;
        cw[0] = 16'd1;   cw[1] = 16'd0;

        repeat (3) @(negedge ap_clk);
        checkOutput("rst_idle", int'(a_idle), 1);
        checkOutput("rst_valid", int'(a_yv), 0);
        checkOutput("rst_done", int'(a_done), 0);
        checkOutput("rst_ready", int'(a_rdy), 0);
        checkOutput("rst_ce", int'(a_x_ce | a_w_ce), 0);
        checkOutput("rst_ydata", int'(a_y), 0);
        rst = 1'b0;
        @(negedge ap_clk);

        $display("[TB] test 1: basic K=3 frame");
        d0 = done_cnt;
        applyStimulus(0);
        collectFrame(4, -1, 0, 0, 1'b0);
        checkBasicFrame("t1");
        checkOutput("t1_first_issue", first_ce, 1);
        checkOutput("t1_latency", valid_at[0] - first_ce, 5);
        checkOutput("t1_throughput", valid_at[1] - valid_at[0], 6);
        checkOutput("t1_done_count", done_cnt - d0, 1);

        $display("[TB] test 4: backpressure and busy start pulse");
        d0 = done_cnt;
        applyStimulus(0);
        collectFrame(4, 1, 10, 3, 1'b0);
        checkBasicFrame("t4");
        checkOutput("t4_stall_stable", stall_bad, 0);
        ce_seen = 0;
        repeat (10) begin
            @(negedge ap_clk);
            if (m_ce || m_valid) ce_seen++;
        end
        checkOutput("t4_no_restart", ce_seen, 0);
        checkOutput("t4_done_count", done_cnt - d0, 1);

        $display("[TB] test 5: reset mid-frame");
        d0 = done_cnt;
        applyStimulus(0);
        @(negedge ap_clk);
        start = 1'b0;
        @(negedge ap_clk);
        checkOutput("t5_in_issue", int'(m_ce), 1);
        rst = 1'b1;
        @(negedge ap_clk);
        checkOutput("t5_idle", int'(m_idle), 1);
        checkOutput("t5_valid", int'(m_valid), 0);
        checkOutput("t5_ce", int'(m_ce), 0);
        rst = 1'b0;
        repeat (8) @(negedge ap_clk);
        checkOutput("t5_no_done", done_cnt - d0, 0);
        checkOutput("t5_still_idle", int'(m_idle), 1);
        applyStimulus(0);
        collectFrame(4, -1, 0, 0, 1'b0);
        checkBasicFrame("t5");

        $display("[TB] test 6: back-to-back frames with ap_start held");
        d0 = done_cnt;
        applyStimulus(0);
        collectFrame(4, -1, 0, 0, 1'b1);
        checkBasicFrame("t6a");
        collectFrame(4, -1, 0, 0, 1'b0);
        checkOutput("t6_restart", first_ce, 1);
        checkBasicFrame("t6b");
        checkOutput("t6_done_count", done_cnt - d0, 2);

        $display("[TB] test 2: saturation K=5");
        applyStimulus(1);
        collectFrame(2, -1, 0, 0, 1'b0);
        checkOutput("t2_pos_y0", got_y[0], 32767);
        checkOutput("t2_pos_y1", got_y[1], 32767);
        checkOutput("t2_latency", valid_at[0] - first_ce, 7);
        for (int i = 0; i < 8; i++) bx[i] = 16'h8000;
        applyStimulus(1);
        collectFrame(2, -1, 0, 0, 1'b0);
        checkOutput("t2_neg_y0", got_y[0], -32768);
        checkOutput("t2_neg_y1", got_y[1], -32768);

        $display("[TB] test 3: rounding K=1 SHIFT=8");
        applyStimulus(2);
        collectFrame(2, -1, 0, 0, 1'b0);
        checkOutput("t3_round_pos", got_y[0], 2);
        checkOutput("t3_round_neg", got_y[1], -1);
        checkOutput("t3_latency", valid_at[0] - first_ce, 3);
        checkOutput("t3_throughput", valid_at[1] - valid_at[0], 4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
